// File: rtl/w_ram_tile_loader.sv
// Weight tile loader: streams one row-major tile from the weight BRAM into banked W-RAM.
// Optional macro W_LOADER_CYCLE_COUNT_EN adds a saturating 16-bit busy-cycle counter port.
module w_ram_tile_loader #(
    parameter int INTEGER_BIT      = 7,
    parameter int W_RAM_ADDR_WIDTH = 7,
    parameter int BRAM_ADDR_WIDTH  = 32,
    parameter int BRAM_LATENCY     = 2,
    parameter int NUM_BANKS        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    input  logic                        ws_os,
    input  logic [INTEGER_BIT-1:0]      col_size,
    input  logic [INTEGER_BIT-1:0]      row_size,
    input  logic [INTEGER_BIT-1:0]      bram_row_size,
    input  logic [INTEGER_BIT-1:0]      bram_col_start_index,
    input  logic [INTEGER_BIT-1:0]      bram_row_start_index,
    input  logic [W_RAM_ADDR_WIDTH-1:0] w_ram_start_addr,
    output logic [BRAM_ADDR_WIDTH-1:0]  addr_w_bram,
    output logic                        enable_w_bram,
    output logic [NUM_BANKS-1:0]        w_ram_write_req,
    output logic [W_RAM_ADDR_WIDTH-1:0] w_ram_write_addr,
    output logic [INTEGER_BIT-1:0]      w_ram_index_addr
`ifdef W_LOADER_CYCLE_COUNT_EN
    ,
    output logic [15:0]                 cycle_count
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DW = $clog2(BRAM_LATENCY + 1);
    localparam logic [INTEGER_BIT-1:0] ONE = INTEGER_BIT'(1);

    logic [1:0]                  state;
    logic [INTEGER_BIT-1:0]      c, r;
    logic [DW-1:0]               drain_cnt;

    logic                        cfg_ws;
    logic [INTEGER_BIT-1:0]      cfg_col, cfg_row, cfg_pitch, cfg_cs, cfg_rs;
    logic [W_RAM_ADDR_WIDTH-1:0] cfg_base;

    logic [BRAM_LATENCY-1:0]     pv;
    logic [INTEGER_BIT-1:0]      pc [BRAM_LATENCY];
    logic [INTEGER_BIT-1:0]      pr [BRAM_LATENCY];

    logic                        accept, kill, issuing;

    assign accept  = (state == S_IDLE) && start && !abort;
    assign kill    = abort && (state != S_IDLE);
    assign issuing = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            c         <= '0;
            r         <= '0;
            drain_cnt <= '0;
            cfg_ws    <= 1'b0;
            cfg_col   <= '0;
            cfg_row   <= '0;
            cfg_pitch <= '0;
            cfg_cs    <= '0;
            cfg_rs    <= '0;
            cfg_base  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cfg_ws    <= ws_os;
                        cfg_col   <= col_size;
                        cfg_row   <= row_size;
                        cfg_pitch <= bram_row_size;
                        cfg_cs    <= bram_col_start_index;
                        cfg_rs    <= bram_row_start_index;
                        cfg_base  <= w_ram_start_addr;
                        c         <= '0;
                        r         <= '0;
                        state     <= (col_size == '0 || row_size == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    drain_cnt <= '0;
                    if (r == cfg_row - ONE) begin
                        r <= '0;
                        if (c == cfg_col - ONE) state <= S_DRAIN;
                        else                    c <= c + ONE;
                    end else begin
                        r <= r + ONE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DW'(BRAM_LATENCY - 1)) state <= S_DONE;
                    else                                   drain_cnt <= drain_cnt + DW'(1);
                end
                default: state <= S_IDLE;
            endcase
            if (kill) state <= S_IDLE;
        end
    end

    // Read-side tag pipeline; stage 0 captures the counters of the read issued this cycle.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            pv <= '0;
            for (int unsigned i = 0; i < BRAM_LATENCY; i++) begin
                pc[i] <= '0;
                pr[i] <= '0;
            end
        end else begin
            pv[0] <= issuing;
            pc[0] <= c;
            pr[0] <= r;
            for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign enable_w_bram = issuing;

    always_comb begin
        addr_w_bram = '0;
        if (issuing) begin
            addr_w_bram = (BRAM_ADDR_WIDTH'(cfg_cs) + BRAM_ADDR_WIDTH'(c)) * BRAM_ADDR_WIDTH'(cfg_pitch)
                        + BRAM_ADDR_WIDTH'(cfg_rs) + BRAM_ADDR_WIDTH'(r);
        end
    end

    logic                   wv;
    logic [INTEGER_BIT-1:0] wc, wr, line, bank, line_div;

    always_comb begin
        wv       = pv[BRAM_LATENCY-1];
        wc       = pc[BRAM_LATENCY-1];
        wr       = pr[BRAM_LATENCY-1];
        line     = cfg_ws ? wc : (cfg_col - ONE - wc);
        bank     = line % INTEGER_BIT'(NUM_BANKS);
        line_div = line / INTEGER_BIT'(NUM_BANKS);
        w_ram_write_req  = '0;
        w_ram_write_addr = '0;
        w_ram_index_addr = '0;
        if (wv) begin
            w_ram_write_req  = NUM_BANKS'(1) << bank;
            w_ram_write_addr = cfg_base + W_RAM_ADDR_WIDTH'(line_div);
            w_ram_index_addr = wr;
        end
    end

`ifdef W_LOADER_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)                               cycle_count <= '0;
        else if (accept)                       cycle_count <= '0;
        else if (busy && cycle_count != '1)    cycle_count <= cycle_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_w_ram_tile_loader.sv
// Directed self-checking bench for w_ram_tile_loader (L=2; one 1-bank and one 2-bank instance).
// Honours W_LOADER_CYCLE_COUNT_EN when defined.
module tb_w_ram_tile_loader;

    logic        clk = 1'b0;
    logic        rst, start, abort, ws_os;
    logic [6:0]  col_size, row_size, pitch, cs, rs, base;

    logic        busy, done, en, req;
    logic [31:0] addr;
    logic [6:0]  waddr, idx;

    logic        busy2, done2, en2;
    logic [1:0]  req2;
    logic [31:0] addr2;
    logic [6:0]  waddr2, idx2;

`ifdef W_LOADER_CYCLE_COUNT_EN
    logic [15:0] cc, cc2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    w_ram_tile_loader #(.INTEGER_BIT(7), .W_RAM_ADDR_WIDTH(7), .BRAM_ADDR_WIDTH(32),
                        .BRAM_LATENCY(2), .NUM_BANKS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .ws_os(ws_os), .col_size(col_size), .row_size(row_size), .bram_row_size(pitch),
        .bram_col_start_index(cs), .bram_row_start_index(rs), .w_ram_start_addr(base),
        .addr_w_bram(addr), .enable_w_bram(en), .w_ram_write_req(req),
        .w_ram_write_addr(waddr), .w_ram_index_addr(idx)
`ifdef W_LOADER_CYCLE_COUNT_EN
        , .cycle_count(cc)
`endif
    );

    w_ram_tile_loader #(.INTEGER_BIT(7), .W_RAM_ADDR_WIDTH(7), .BRAM_ADDR_WIDTH(32),
                        .BRAM_LATENCY(2), .NUM_BANKS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy2), .done(done2),
        .ws_os(ws_os), .col_size(col_size), .row_size(row_size), .bram_row_size(pitch),
        .bram_col_start_index(cs), .bram_row_start_index(rs), .w_ram_start_addr(base),
        .addr_w_bram(addr2), .enable_w_bram(en2), .w_ram_write_req(req2),
        .w_ram_write_addr(waddr2), .w_ram_index_addr(idx2)
`ifdef W_LOADER_CYCLE_COUNT_EN
        , .cycle_count(cc2)
`endif
    );

    int bram_tbl [6] = '{10, 11, 12, 18, 19, 20};
    int wa_os    [6] = '{4, 4, 4, 5, 5, 5};
    int wa_ws    [6] = '{5, 5, 5, 4, 4, 4};
    int idx_tbl  [6] = '{0, 1, 2, 0, 1, 2};
    int nb_req   [4] = '{1, 2, 1, 2};
    int nb_addr  [4] = '{0, 0, 1, 1};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic ws, input int col, input int row, input int p,
                           input int c0, input int r0, input int b);
        ws_os    = ws;
        col_size = 7'(col);
        row_size = 7'(row);
        pitch    = 7'(p);
        cs       = 7'(c0);
        rs       = 7'(r0);
        base     = 7'(b);
    endtask

    // col=2,row=3,pitch=8,start (1,2),base 4; optional second start pulse at cycle restart_at.
    task automatic run_basic(input logic ws, input int restart_at);
        int ndone;
        int k;
        ndone = 0;
        set_cfg(ws, 2, 3, 8, 1, 2, 4);
        start = 1'b1;
        tick();
        set_cfg(~ws, 7, 7, 3, 0, 0, 0);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            start = (cyc == restart_at);
            if (cyc >= 1 && cyc <= 6) begin
                check("rd_en",   32'(en),   32'd1);
                check("rd_addr", addr,      32'(bram_tbl[cyc-1]));
            end else begin
                check("rd_en",   32'(en),   32'd0);
                check("rd_addr", addr,      32'd0);
            end
            if (cyc >= 3 && cyc <= 8) begin
                k = cyc - 3;
                check("wr_req",  32'(req),   32'd1);
                check("wr_addr", 32'(waddr), 32'(ws ? wa_os[k] : wa_ws[k]));
                check("wr_idx",  32'(idx),   32'(idx_tbl[k]));
            end else begin
                check("wr_req",  32'(req),   32'd0);
                check("wr_addr", 32'(waddr), 32'd0);
                check("wr_idx",  32'(idx),   32'd0);
            end
            check("done", 32'(done), 32'(cyc == 9));
            check("busy", 32'(busy), 32'(cyc <= 9));
            if (done) ndone++;
            tick();
        end
        start = 1'b0;
        check("done_count", 32'(ndone), 32'd1);
    endtask

    initial begin
        int nrd, nwr, ndone, done_at;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_en",   32'(en),   32'd0);
        check("rst_addr", addr,      32'd0);
        check("rst_req",  32'(req),  32'd0);
        check("rst_req2", 32'(req2), 32'd0);
        rst = 1'b0;
        tick();

        // straight and reversed line order
        run_basic(1'b1, 0);
        tick();
        run_basic(1'b0, 0);
        tick();

        // two banks, one element per line
        set_cfg(1'b1, 4, 1, 1, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc >= 3 && cyc <= 6) begin
                check("nb_req",  32'(req2),   32'(nb_req[cyc-3]));
                check("nb_addr", 32'(waddr2), 32'(nb_addr[cyc-3]));
            end else begin
                check("nb_req",  32'(req2),   32'd0);
            end
            check("nb_done", 32'(done2), 32'(cyc == 7));
            tick();
        end

        // zero-size tile
        set_cfg(1'b1, 0, 5, 1, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_busy1", 32'(busy), 32'd1);
        check("zero_done1", 32'(done), 32'd1);
        check("zero_en1",   32'(en),   32'd0);
        check("zero_req1",  32'(req),  32'd0);
        tick();
        check("zero_busy2", 32'(busy), 32'd0);
        check("zero_done2", 32'(done), 32'd0);
        check("zero_en2",   32'(en),   32'd0);
        tick();

        // abort at cycle 4, then a clean restart at cycle 6
        set_cfg(1'b1, 3, 3, 8, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            check("ab_en",   32'(en), 32'd1);
            check("ab_addr", addr,    32'(cyc - 1));
            tick();
        end
        abort = 1'b1;
        check("ab4_en",   32'(en),  32'd1);
        check("ab4_addr", addr,     32'd8);
        check("ab4_req",  32'(req), 32'd1);
        check("ab4_idx",  32'(idx), 32'd1);
        tick();
        abort = 1'b0;
        check("ab5_busy", 32'(busy), 32'd0);
        check("ab5_en",   32'(en),   32'd0);
        check("ab5_req",  32'(req),  32'd0);
        check("ab5_done", 32'(done), 32'd0);
        tick();
        check("ab6_req",  32'(req),  32'd0);
        check("ab6_done", 32'(done), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        nrd = 0; nwr = 0; ndone = 0; done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            if (en) nrd++;
            if (req) nwr++;
            if (done) begin
                ndone++;
                done_at = i;
            end
            tick();
        end
        check("rs_reads",   32'(nrd),     32'd9);
        check("rs_writes",  32'(nwr),     32'd9);
        check("rs_dones",   32'(ndone),   32'd1);
        check("rs_done_at", 32'(done_at), 32'd12);

        // second start pulse during a load is ignored
        run_basic(1'b1, 3);
`ifdef W_LOADER_CYCLE_COUNT_EN
        check("cycle_count", 32'(cc), 32'd9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
